// File: rtl/wb_stage_pkg.sv
// Shared definitions for the writeback stage: writeback-source codes,
// load-operation codes, reset PC default and the stage-register layout.
package wb_stage_pkg;

    localparam logic [1:0] WB_SEL_ALU = 2'b00;
    localparam logic [1:0] WB_SEL_MEM = 2'b01;
    localparam logic [1:0] WB_SEL_PC8 = 2'b10;

    localparam logic [2:0] LOAD_LW  = 3'b000;
    localparam logic [2:0] LOAD_LH  = 3'b001;
    localparam logic [2:0] LOAD_LHU = 3'b010;
    localparam logic [2:0] LOAD_LB  = 3'b011;
    localparam logic [2:0] LOAD_LBU = 3'b100;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

    // Contents of the M/W pipeline register.
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic        reg_write;
        logic [4:0]  rd_addr;
        logic [1:0]  wb_sel;
        logic [2:0]  load_op;
        logic [1:0]  addr_lo;
        logic [31:0] alu_result;
        logic [31:0] mem_rdata;
    } wb_entry_t;

endpackage

// File: rtl/wb_stage_if.sv
// Bundle of stage control, M-stage inputs and W-stage outputs.
// master drives the M side and observes W; slave is the writeback stage.
interface wb_stage_if;
    logic        en;
    logic        flush;
    logic        m_valid;
    logic [31:0] m_pc;
    logic        m_reg_write;
    logic [4:0]  m_rd_addr;
    logic [1:0]  m_wb_sel;
    logic [2:0]  m_load_op;
    logic [1:0]  m_addr_lo;
    logic [31:0] m_alu_result;
    logic [31:0] m_mem_rdata;
    logic        w_reg_write;
    logic [4:0]  w_rd_addr;
    logic [31:0] w_wdata;
    logic [31:0] w_pcplus4;
    logic        w_valid;
    logic [31:0] retire_cnt;

    modport master (
        output en, flush, m_valid, m_pc, m_reg_write, m_rd_addr, m_wb_sel,
               m_load_op, m_addr_lo, m_alu_result, m_mem_rdata,
        input  w_reg_write, w_rd_addr, w_wdata, w_pcplus4, w_valid, retire_cnt
    );

    modport slave (
        input  en, flush, m_valid, m_pc, m_reg_write, m_rd_addr, m_wb_sel,
               m_load_op, m_addr_lo, m_alu_result, m_mem_rdata,
        output w_reg_write, w_rd_addr, w_wdata, w_pcplus4, w_valid, retire_cnt
    );
endinterface

// File: rtl/wb_stage_load_ext.sv
// Load-data extension: picks the addressed byte/halfword out of an aligned
// memory word and sign- or zero-extends it. Unknown load codes behave as LW.
module wb_stage_load_ext
    import wb_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  load_op,
    output logic [31:0] ext_data
);

    logic [15:0] half_s;
    logic [7:0]  byte_s;

    // Select the addressed halfword and byte lanes.
    always_comb begin
        half_s = 16'h0000;
        byte_s = 8'h00;
        if (addr_lo[1]) begin
            half_s = rdata[31:16];
        end else begin
            half_s = rdata[15:0];
        end
        case (addr_lo)
            2'd0:    byte_s = rdata[7:0];
            2'd1:    byte_s = rdata[15:8];
            2'd2:    byte_s = rdata[23:16];
            2'd3:    byte_s = rdata[31:24];
            default: byte_s = rdata[7:0];
        endcase
    end

    // Extend the selected lane according to the load operation.
    always_comb begin
        ext_data = rdata;
        case (load_op)
            LOAD_LW:  ext_data = rdata;
            LOAD_LH:  ext_data = {{16{half_s[15]}}, half_s};
            LOAD_LHU: ext_data = {16'h0000, half_s};
            LOAD_LB:  ext_data = {{24{byte_s[7]}}, byte_s};
            LOAD_LBU: ext_data = {24'h00_0000, byte_s};
            default:  ext_data = rdata;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: M/W pipeline register, writeback-source mux driving the
// register-file write port, and a retired-instruction counter.
// W outputs are decoded only from the stage register, never from M inputs.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    wb_stage_if.slave  bus
);

    wb_entry_t   stage_r;
    wb_entry_t   bubble_s;
    wb_entry_t   incoming_s;
    logic [31:0] retire_r;
    logic [31:0] load_data_s;
    logic [31:0] wdata_s;

    // Empty slot loaded on reset and flush.
    always_comb begin
        bubble_s    = '0;
        bubble_s.pc = RESET_PC;
    end

    // Pack the M-stage inputs into a stage entry.
    always_comb begin
        incoming_s            = '0;
        incoming_s.valid      = bus.m_valid;
        incoming_s.pc         = bus.m_pc;
        incoming_s.reg_write  = bus.m_reg_write;
        incoming_s.rd_addr    = bus.m_rd_addr;
        incoming_s.wb_sel     = bus.m_wb_sel;
        incoming_s.load_op    = bus.m_load_op;
        incoming_s.addr_lo    = bus.m_addr_lo;
        incoming_s.alu_result = bus.m_alu_result;
        incoming_s.mem_rdata  = bus.m_mem_rdata;
    end

    // Stage register: flush beats enable, enable beats hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_r <= bubble_s;
        end else if (bus.flush) begin
            stage_r <= bubble_s;
        end else if (bus.en) begin
            stage_r <= incoming_s;
        end else begin
            stage_r <= stage_r;
        end
    end

    // Count an instruction when it leaves W normally; a flushed one does not count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retire_r <= 32'h0000_0000;
        end else if (stage_r.valid && bus.en && !bus.flush) begin
            retire_r <= retire_r + 32'd1;
        end else begin
            retire_r <= retire_r;
        end
    end

    wb_stage_load_ext u_load_ext (
        .rdata    (stage_r.mem_rdata),
        .addr_lo  (stage_r.addr_lo),
        .load_op  (stage_r.load_op),
        .ext_data (load_data_s)
    );

    // Writeback source select; the reserved code writes zero.
    always_comb begin
        wdata_s = 32'h0000_0000;
        case (stage_r.wb_sel)
            WB_SEL_ALU: wdata_s = stage_r.alu_result;
            WB_SEL_MEM: wdata_s = load_data_s;
            WB_SEL_PC8: wdata_s = stage_r.pc + 32'd8;
            default:    wdata_s = 32'h0000_0000;
        endcase
    end

    // Writes to $zero are suppressed here so the GRF and forwarding agree.
    assign bus.w_reg_write = stage_r.valid & stage_r.reg_write & (stage_r.rd_addr != 5'd0);
    assign bus.w_rd_addr   = stage_r.rd_addr;
    assign bus.w_wdata     = wdata_s;
    assign bus.w_pcplus4   = stage_r.pc + 32'd4;
    assign bus.w_valid     = stage_r.valid;
    assign bus.retire_cnt  = retire_r;

endmodule
